// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and ALU operand
// forwarding select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register fields seen by the hazard controller and the control
// strobes/forwarding selects it drives back into the datapath.
interface hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_dst;
   logic              ex_memread;
   logic [REG_AW-1:0] mem_dst;
   logic              mem_regwrite;
   logic [REG_AW-1:0] wb_dst;
   logic              wb_regwrite;
   logic              br_taken;
   logic              cnt_clr;
   logic              pc_we;
   logic              ifid_we;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              exmem_flush;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_memread, mem_dst, mem_regwrite,
             wb_dst, wb_regwrite, br_taken, cnt_clr,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, fwd_a, fwd_b,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_memread, mem_dst, mem_regwrite,
             wb_dst, wb_regwrite, br_taken, cnt_clr,
      output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, fwd_a, fwd_b,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand; the younger EX/MEM result wins over MEM/WB.
module fwd_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_src,
   input  logic [REG_AW-1:0] i_mem_dst,
   input  logic              i_mem_regwrite,
   input  logic [REG_AW-1:0] i_wb_dst,
   input  logic              i_wb_regwrite,
   output logic [1:0]        o_sel
);
   always_comb begin
      o_sel = FWD_RF;
      if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_src)) begin
         o_sel = FWD_MEM;
      end else if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_src)) begin
         o_sel = FWD_WB;
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, taken-branch flush, operand forwarding
// and saturating stall/flush event counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_lu;
   logic             w_stall_evt;
   logic             w_flush_evt;
   logic             w_pc_we;
   logic             w_ifid_we;
   logic             w_ifid_flush;
   logic             w_idex_bubble;
   logic             w_exmem_flush;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   assign w_lu = bus.ex_memread && (bus.ex_dst != '0) &&
                 ((bus.ex_dst == bus.id_rs) || (bus.ex_dst == bus.id_rt));

   // Load-use only stalls from RUN: in STALL the load has moved on, in FLUSH IF/ID is a NOP.
   always_comb begin
      w_next        = RUN;
      w_stall_evt   = 1'b0;
      w_flush_evt   = 1'b0;
      w_pc_we       = 1'b1;
      w_ifid_we     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_exmem_flush = 1'b0;
      if (bus.br_taken) begin
         w_next        = FLUSH;
         w_flush_evt   = 1'b1;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_exmem_flush = 1'b1;
      end else if ((r_state == RUN) && w_lu) begin
         w_next        = STALL;
         w_stall_evt   = 1'b1;
         w_pc_we       = 1'b0;
         w_ifid_we     = 1'b0;
         w_idex_bubble = 1'b1;
      end
      if (rst) begin
         w_pc_we       = 1'b0;
         w_ifid_we     = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_exmem_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
         end else begin
            if (w_stall_evt && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .i_src          (bus.ex_rs),
      .i_mem_dst      (bus.mem_dst),
      .i_mem_regwrite (bus.mem_regwrite),
      .i_wb_dst       (bus.wb_dst),
      .i_wb_regwrite  (bus.wb_regwrite),
      .o_sel          (w_fwd_a)
   );

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .i_src          (bus.ex_rt),
      .i_mem_dst      (bus.mem_dst),
      .i_mem_regwrite (bus.mem_regwrite),
      .i_wb_dst       (bus.wb_dst),
      .i_wb_regwrite  (bus.wb_regwrite),
      .o_sel          (w_fwd_b)
   );

   assign bus.pc_we       = w_pc_we;
   assign bus.ifid_we     = w_ifid_we;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_bubble = w_idex_bubble;
   assign bus.exmem_flush = w_exmem_flush;
   assign bus.fwd_a       = rst ? FWD_RF : w_fwd_a;
   assign bus.fwd_b       = rst ? FWD_RF : w_fwd_b;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;
endmodule
